// File: rtl/axi_riscv_atomics_pkg.sv
// Shared defaults and SC verdict encoding for the RISC-V atomics reservation logic.
package axi_riscv_atomics_pkg;

  localparam int unsigned RESV_ADDR_WIDTH     = 64;
  localparam int unsigned RESV_ID_WIDTH       = 4;
  localparam int unsigned RESV_NUM            = 4;
  localparam int unsigned RESV_GRANULE_BITS   = 3;
  localparam int unsigned RESV_TIMEOUT_CYCLES = 0;

  // Value carried on sc_rsp_ok_o
  localparam logic SC_OK   = 1'b1;
  localparam logic SC_FAIL = 1'b0;

  // Index width that never collapses to zero bits
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lzc.sv
// Leading/trailing zero counter. MODE=0 returns the index of the lowest set
// bit; MODE=1 returns the number of zeros above the highest set bit.
module lzc #(
  parameter int unsigned WIDTH = 2,
  parameter bit          MODE  = 1'b0,
  localparam int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  // Priority scan; the last matching assignment wins
  always_comb begin
    cnt_o   = '0;
    empty_o = ~|in_i;
    if (MODE == 1'b0) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (in_i[i]) cnt_o = CNT_WIDTH'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (in_i[i]) cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
      end
    end
  end

endmodule

// File: rtl/axi_riscv_resv_table.sv
// LR/SC reservation table: one reservation per requester ID, invalidated by
// SC, by snooped committed writes and (optionally) by age.
module axi_riscv_resv_table
  import axi_riscv_atomics_pkg::*;
#(
  parameter int unsigned AddrWidth     = RESV_ADDR_WIDTH,
  parameter int unsigned IdWidth       = RESV_ID_WIDTH,
  parameter int unsigned NumResv       = RESV_NUM,
  parameter int unsigned GranuleBits   = RESV_GRANULE_BITS,
  parameter int unsigned TimeoutCycles = RESV_TIMEOUT_CYCLES
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         lr_valid_i,
  output logic                         lr_ready_o,
  input  logic [IdWidth-1:0]           lr_id_i,
  input  logic [AddrWidth-1:0]         lr_addr_i,
  input  logic                         sc_valid_i,
  output logic                         sc_ready_o,
  input  logic [IdWidth-1:0]           sc_id_i,
  input  logic [AddrWidth-1:0]         sc_addr_i,
  output logic                         sc_rsp_valid_o,
  output logic                         sc_rsp_ok_o,
  input  logic                         snp_valid_i,
  input  logic [AddrWidth-1:0]         snp_addr_i,
  output logic [$clog2(NumResv+1)-1:0] occupancy_o
);

  localparam int unsigned GranW = AddrWidth - GranuleBits;
  localparam int unsigned IdxW  = idx_width(NumResv);
  localparam int unsigned AgeW  = idx_width(TimeoutCycles + 1);
  localparam int unsigned OccW  = $clog2(NumResv + 1);
  localparam logic [AgeW-1:0] AgeMax  = AgeW'(TimeoutCycles);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumResv - 1);

  // Handshake: a request transfers on a rising edge where valid and ready are
  // both high; requesters hold id/addr stable until then. SC always has
  // priority, so LR is held off in any cycle where sc_valid_i is high. Snoops
  // have no ready and always take effect in the cycle they are presented.

  logic [NumResv-1:0] valid_q, valid_d;
  logic [IdWidth-1:0] id_q    [NumResv];
  logic [IdWidth-1:0] id_d    [NumResv];
  logic [GranW-1:0]   gran_q  [NumResv];
  logic [GranW-1:0]   gran_d  [NumResv];
  logic [AgeW-1:0]    age_q   [NumResv];
  logic [AgeW-1:0]    age_d   [NumResv];
  logic [IdxW-1:0]    vict_q, vict_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_ok_q, rsp_ok_d;

  logic [GranW-1:0] lr_gran, sc_gran, snp_gran;
  logic             lr_fire, sc_fire;
  logic             lr_hit, sc_match, sc_ok, free_none, lr_evict;
  logic [IdxW-1:0]  lr_hit_idx, free_idx, lr_idx;
  logic [OccW-1:0]  occ_cnt;

  assign lr_gran  = lr_addr_i[AddrWidth-1:GranuleBits];
  assign sc_gran  = sc_addr_i[AddrWidth-1:GranuleBits];
  assign snp_gran = snp_addr_i[AddrWidth-1:GranuleBits];

  generate
    if (GranuleBits > 0) begin : g_offset
      logic unused_offset;
      assign unused_offset = ^{lr_addr_i[GranuleBits-1:0], sc_addr_i[GranuleBits-1:0],
                               snp_addr_i[GranuleBits-1:0]};
    end
  endgenerate

  assign sc_ready_o = ~rst_i;
  assign lr_ready_o = ~rst_i & ~sc_valid_i;
  assign lr_fire    = lr_valid_i & lr_ready_o;
  assign sc_fire    = sc_valid_i & sc_ready_o;

  // Lowest free entry for a new LR
  lzc #(
    .WIDTH (NumResv),
    .MODE  (1'b0)
  ) i_free_lzc (
    .in_i    (~valid_q),
    .cnt_o   (free_idx),
    .empty_o (free_none)
  );

  // Lookups against the registered table (pre-update state)
  always_comb begin
    lr_hit     = 1'b0;
    lr_hit_idx = '0;
    sc_match   = 1'b0;
    for (int i = 0; i < NumResv; i++) begin
      if (valid_q[i] && id_q[i] == lr_id_i) begin
        lr_hit     = 1'b1;
        lr_hit_idx = IdxW'(i);
      end
      if (valid_q[i] && id_q[i] == sc_id_i && gran_q[i] == sc_gran) sc_match = 1'b1;
    end
    // A snoop to the same granule in the same cycle kills the SC
    sc_ok    = sc_match & ~(snp_valid_i & (snp_gran == sc_gran));
    lr_evict = ~lr_hit & free_none;
    lr_idx   = lr_hit ? lr_hit_idx : (free_none ? vict_q : free_idx);
  end

  // Next table state: ageing, then snoop and SC kills, then LR fill (LR wins)
  always_comb begin
    logic [AgeW-1:0] age_nxt;
    vict_d = vict_q;
    if (lr_fire && lr_evict) vict_d = (vict_q == LastIdx) ? '0 : vict_q + IdxW'(1);
    for (int i = 0; i < NumResv; i++) begin
      valid_d[i] = valid_q[i];
      id_d[i]    = id_q[i];
      gran_d[i]  = gran_q[i];
      age_d[i]   = age_q[i];
      age_nxt    = (age_q[i] == AgeMax) ? age_q[i] : age_q[i] + AgeW'(1);
      if (TimeoutCycles > 0 && valid_q[i]) begin
        age_d[i] = age_nxt;
        if (age_nxt == AgeMax) valid_d[i] = 1'b0;
      end
      if (snp_valid_i && gran_q[i] == snp_gran) valid_d[i] = 1'b0;
      if (sc_fire) begin
        if (id_q[i] == sc_id_i) valid_d[i] = 1'b0;
        if (sc_ok && gran_q[i] == sc_gran) valid_d[i] = 1'b0;
      end
      if (lr_fire && lr_idx == IdxW'(i)) begin
        valid_d[i] = 1'b1;
        id_d[i]    = lr_id_i;
        gran_d[i]  = lr_gran;
        age_d[i]   = '0;
      end
    end
    rsp_valid_d = sc_fire;
    rsp_ok_d    = sc_fire & sc_ok;
  end

  // Count of valid entries from registered state
  always_comb begin
    occ_cnt = '0;
    for (int i = 0; i < NumResv; i++) occ_cnt = occ_cnt + OccW'(valid_q[i]);
  end

  // Register update with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q     <= '0;
      vict_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_ok_q    <= SC_FAIL;
      for (int i = 0; i < NumResv; i++) begin
        id_q[i]   <= '0;
        gran_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      vict_q      <= vict_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_ok_q    <= rsp_ok_d;
      for (int i = 0; i < NumResv; i++) begin
        id_q[i]   <= id_d[i];
        gran_q[i] <= gran_d[i];
        age_q[i]  <= age_d[i];
      end
    end
  end

  // Reset masks the registered outputs so a response pending from the cycle
  // before reset never becomes visible
  assign sc_rsp_valid_o = rsp_valid_q & ~rst_i;
  assign sc_rsp_ok_o    = rsp_ok_q & rsp_valid_q & ~rst_i;
  assign occupancy_o    = rst_i ? '0 : occ_cnt;

endmodule

// File: tb/tb_axi_riscv_resv_table.sv
// Directed bench for axi_riscv_resv_table: a default instance (no expiry) and
// a TimeoutCycles=8 instance share the same stimulus.
module tb_axi_riscv_resv_table;

  localparam int AW = 64;
  localparam int IW = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          lr_valid, sc_valid, snp_valid;
  logic [IW-1:0] lr_id, sc_id;
  logic [AW-1:0] lr_addr, sc_addr, snp_addr;

  logic       lr_ready, sc_ready, rsp_valid, rsp_ok;
  logic [2:0] occ;
  logic       lr_ready_t, sc_ready_t, rsp_valid_t, rsp_ok_t;
  logic [2:0] occ_t;

  axi_riscv_resv_table dut (
    .clk_i(clk), .rst_i(rst),
    .lr_valid_i(lr_valid), .lr_ready_o(lr_ready), .lr_id_i(lr_id), .lr_addr_i(lr_addr),
    .sc_valid_i(sc_valid), .sc_ready_o(sc_ready), .sc_id_i(sc_id), .sc_addr_i(sc_addr),
    .sc_rsp_valid_o(rsp_valid), .sc_rsp_ok_o(rsp_ok),
    .snp_valid_i(snp_valid), .snp_addr_i(snp_addr),
    .occupancy_o(occ)
  );

  axi_riscv_resv_table #(.TimeoutCycles(8)) dut_to (
    .clk_i(clk), .rst_i(rst),
    .lr_valid_i(lr_valid), .lr_ready_o(lr_ready_t), .lr_id_i(lr_id), .lr_addr_i(lr_addr),
    .sc_valid_i(sc_valid), .sc_ready_o(sc_ready_t), .sc_id_i(sc_id), .sc_addr_i(sc_addr),
    .sc_rsp_valid_o(rsp_valid_t), .sc_rsp_ok_o(rsp_ok_t),
    .snp_valid_i(snp_valid), .snp_addr_i(snp_addr),
    .occupancy_o(occ_t)
  );

  // scoreboard
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [0:0]  exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_lr_ready"}, lr_ready, 0);
    check_eq({tag, "_sc_ready"}, sc_ready, 0);
    check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
    check_eq({tag, "_rsp_ok"}, rsp_ok, 0);
    check_eq({tag, "_occ"}, occ, 0);
  endtask

  task automatic do_reset(input string tag);
    lr_valid = 0; sc_valid = 0; snp_valid = 0;
    rst = 1;
    #1;
    check_reset_outputs({tag, "_rst_a"});
    step();
    check_reset_outputs({tag, "_rst_b"});
    rst = 0;
  endtask

  task automatic do_lr(input string tag, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                       input logic snp_en, input logic [AW-1:0] saddr);
    lr_valid = 1; lr_id = id; lr_addr = addr;
    snp_valid = snp_en; snp_addr = saddr;
    #1;
    check_eq({tag, "_lr_ready"}, lr_ready, 1);
    step();
    lr_valid = 0; snp_valid = 0;
  endtask

  // LR is also raised during every SC to show it is held off
  task automatic do_sc(input string tag, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                       input logic snp_en, input logic [AW-1:0] saddr,
                       input logic exp_ok, input logic exp_ok_t);
    sc_valid = 1; sc_id = id; sc_addr = addr;
    lr_valid = 1;
    snp_valid = snp_en; snp_addr = saddr;
    exp_q.push_back(exp_ok);
    #1;
    check_eq({tag, "_lr_held"}, lr_ready, 0);
    check_eq({tag, "_sc_ready"}, sc_ready, 1);
    step();
    sc_valid = 0; lr_valid = 0; snp_valid = 0;
    check_eq({tag, "_rsp_valid"}, rsp_valid, 1);
    check_eq({tag, "_rsp_ok"}, rsp_ok, exp_q.pop_front());
    check_eq({tag, "_rsp_valid_t"}, rsp_valid_t, 1);
    check_eq({tag, "_rsp_ok_t"}, rsp_ok_t, exp_ok_t);
    step();
    check_eq({tag, "_rsp_drop"}, rsp_valid, 0);
    check_eq({tag, "_ok_drop"}, rsp_ok, 0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1; lr_valid = 0; sc_valid = 0; snp_valid = 0;
    lr_id = '0; sc_id = '0; lr_addr = '0; sc_addr = '0; snp_addr = '0;

    // basic LR/SC with offset inside granule
    do_reset("t1");
    do_lr("t1", 2, 64'h1000, 0, 0);
    check_eq("t1_occ_after_lr", occ, 1);
    do_sc("t1", 2, 64'h1004, 0, 0, 1, 1);
    check_eq("t1_occ_after_sc", occ, 0);

    // snoop kills the reservation
    do_reset("t2");
    do_lr("t2", 2, 64'h1000, 0, 0);
    do_lr("t2_snp", 0, 64'h0, 0, 0);
    snp_valid = 1; snp_addr = 64'h1000; step(); snp_valid = 0;
    check_eq("t2_occ_after_snp", occ, 1);
    do_sc("t2", 2, 64'h1000, 0, 0, 0, 0);

    // different granule fails and still clears the id's entry
    do_reset("t3");
    do_lr("t3", 2, 64'h1000, 0, 0);
    do_sc("t3", 2, 64'h1008, 0, 0, 0, 0);
    check_eq("t3_occ", occ, 0);

    // round-robin eviction with a full table
    do_reset("t4");
    for (int i = 0; i < 5; i++) do_lr("t4", IW'(i), 64'h3000 + 64'(i) * 64'h40, 0, 0);
    check_eq("t4_occ_full", occ, 4);
    do_sc("t4_id0", 0, 64'h3000, 0, 0, 0, 0);
    check_eq("t4_occ_after_id0", occ, 4);
    do_sc("t4_id4", 4, 64'h3100, 0, 0, 1, 1);
    check_eq("t4_occ_after_id4", occ, 3);

    // same-id LR overwrites
    do_reset("t5");
    do_lr("t5a", 1, 64'h5000, 0, 0);
    do_lr("t5b", 1, 64'h6000, 0, 0);
    check_eq("t5_occ", occ, 1);
    do_sc("t5", 1, 64'h5000, 0, 0, 0, 0);
    check_eq("t5_occ_after", occ, 0);

    // same-cycle SC+snoop, then same-cycle LR+snoop
    do_reset("t6");
    do_lr("t6a", 1, 64'h2000, 0, 0);
    do_sc("t6a", 1, 64'h2000, 1, 64'h2000, 0, 0);
    check_eq("t6_occ_after_sc", occ, 0);
    do_lr("t6b", 1, 64'h2000, 1, 64'h2000);
    check_eq("t6_occ_after_lr_snp", occ, 1);
    do_sc("t6b", 1, 64'h2000, 0, 0, 1, 1);

    // successful SC clears other ids on the same granule
    do_reset("t7");
    do_lr("t7a", 1, 64'h7000, 0, 0);
    do_lr("t7b", 2, 64'h7004, 0, 0);
    check_eq("t7_occ", occ, 2);
    do_sc("t7_id1", 1, 64'h7000, 0, 0, 1, 1);
    check_eq("t7_occ_after", occ, 0);
    do_sc("t7_id2", 2, 64'h7000, 0, 0, 0, 0);

    // expiry: SC transfers 7, 8 and 9 cycles after the LR
    do_reset("t8");
    do_lr("t8a", 3, 64'h4000, 0, 0);
    idle(6);
    do_sc("t8_c7", 3, 64'h4000, 0, 0, 1, 1);
    do_lr("t8b", 3, 64'h4000, 0, 0);
    idle(7);
    do_sc("t8_c8", 3, 64'h4000, 0, 0, 1, 1);
    do_lr("t8c", 3, 64'h4000, 0, 0);
    idle(8);
    check_eq("t8_occ_t_expired", occ_t, 0);
    check_eq("t8_occ_kept", occ, 1);
    do_sc("t8_c9", 3, 64'h4000, 0, 0, 1, 0);

    // reset clears reservations
    do_reset("t9");
    do_lr("t9", 5, 64'h5000, 0, 0);
    check_eq("t9_occ_before", occ, 1);
    do_reset("t9_pulse");
    check_eq("t9_occ_after", occ, 0);
    do_sc("t9", 5, 64'h5000, 0, 0, 0, 0);

    // SC accepted just before reset: response suppressed
    do_reset("t10");
    do_lr("t10", 6, 64'h6000, 0, 0);
    sc_valid = 1; sc_id = 6; sc_addr = 64'h6000;
    step();
    sc_valid = 0;
    rst = 1;
    #1;
    check_eq("t10_rsp_in_rst", rsp_valid, 0);
    check_eq("t10_ok_in_rst", rsp_ok, 0);
    step();
    rst = 0;
    #1;
    check_eq("t10_rsp_after_rst", rsp_valid, 0);
    check_eq("t10_occ_after_rst", occ, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
